// File: rtl/mtm_alu_deserializer.sv
// Serial input stage of mtm_Alu: frames 11-bit serial words into an 8-data + 1-cmd
// packet, checks count/CRC-4/opcode, and presents A, B, OP with one outcome pulse.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        out_valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  state_t      state, state_nxt;
  logic        is_cmd;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [63:0] ba;
  logic [3:0]  data_cnt;

  logic        frame_done, frame_bad, data_done, cmd_done;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_crc, crc_calc;
  logic        op_ok;

  // CRC-4, x^4+x+1, init 0, MSB first over {B, A, 1'b1, OP}
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ d[67 - i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sin) state_nxt = TYPE;
      TYPE:    state_nxt = PAYLOAD;
      PAYLOAD: if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state == STOP) && sin;
    frame_bad  = (state == STOP) && !sin;
    data_done  = frame_done && !is_cmd;
    cmd_done   = frame_done && is_cmd;
    cmd_op     = shreg[6:4];
    cmd_crc    = shreg[3:0];
    crc_calc   = crc4({ba, 1'b1, cmd_op});
    case (cmd_op)
      3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_cmd    <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ba        <= '0;
      data_cnt  <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_op    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_op    <= 1'b0;

      case (state)
        TYPE: begin
          is_cmd  <= sin;
          bit_cnt <= '0;
        end
        PAYLOAD: begin
          shreg   <= {shreg[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase

      if (data_done) begin
        ba <= {ba[55:0], shreg};
        if (data_cnt != 4'd9) data_cnt <= data_cnt + 4'd1;
      end

      // Outcome priority: count, then CRC, then opcode; exactly one pulse
      if (cmd_done) begin
        data_cnt <= '0;
        if (data_cnt != 4'd8)         err_data <= 1'b1;
        else if (cmd_crc != crc_calc) err_crc  <= 1'b1;
        else if (!op_ok)              err_op   <= 1'b1;
        else begin
          out_valid <= 1'b1;
          b         <= ba[63:32];
          a         <= ba[31:0];
          op        <= cmd_op;
        end
      end

      if (frame_bad) begin
        err_data <= 1'b1;
        data_cnt <= '0;
        ba       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized self-checking bench for mtm_alu_deserializer with a packet-level reference model.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid, err_data, err_crc, err_op;

  mtm_alu_deserializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .err_data (err_data),
    .err_crc  (err_crc),
    .err_op   (err_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] P_V  = 32'h0100_0000;
  localparam logic [31:0] P_ED = 32'h0001_0000;
  localparam logic [31:0] P_EC = 32'h0000_0100;
  localparam logic [31:0] P_EO = 32'h0000_0001;

  // Expected held outputs
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [2:0]  exp_op = '0;

  // Pulse monitor
  int n_v = 0, n_ed = 0, n_ec = 0, n_eo = 0, n_multi = 0;
  int s_v, s_ed, s_ec, s_eo;
  logic [66:0] got_q[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_v++;
      got_q.push_back({a, b, op});
    end
    if (err_data === 1'b1) n_ed++;
    if (err_crc === 1'b1)  n_ec++;
    if (err_op === 1'b1)   n_eo++;
    if ((32'(out_valid) + 32'(err_data) + 32'(err_crc) + 32'(err_op)) > 1) n_multi++;
  end

  task automatic snap();
    s_v = n_v; s_ed = n_ed; s_ec = n_ec; s_eo = n_eo;
  endtask

  function automatic logic [31:0] pulse_delta();
    return {8'(n_v - s_v), 8'(n_ed - s_ed), 8'(n_ec - s_ec), 8'(n_eo - s_eo)};
  endfunction

  // Reference CRC: remainder of ({B,A,1,OP} * x^4) mod (x^4+x+1)
  function automatic logic [3:0] ref_crc(input logic [63:0] ba, input logic [2:0] o);
    logic [71:0] m;
    m = {ba, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [31:0] classify(input int ndata, input logic [63:0] ba,
                                           input logic [7:0] cmd);
    if (ndata != 8) return P_ED;
    if (cmd[3:0] != ref_crc(ba, cmd[6:4])) return P_EC;
    if (!(cmd[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) return P_EO;
    return P_V;
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] p, input logic stop_v);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    send_bit(stop_v);
  endtask

  task automatic send_data(input logic [63:0] ba, input int n);
    for (int j = 0; j < n; j++) send_frame(1'b0, ba[63 - 8*j -: 8], 1'b1);
  endtask

  function automatic logic [2:0] rand_op();
    logic [2:0] t [4];
    t = '{3'b000, 3'b001, 3'b100, 3'b101};
    return t[$urandom_range(0, 3)];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sin   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    idle(20);
    checks++;
    if ({a, b, op} !== 67'd0) $display("FAIL reset_outputs: got a=%h b=%h op=%b, want 0", a, b, op);
    else passed++;
    checks++;
    if ({out_valid, err_data, err_crc, err_op} !== 4'b0000)
      $display("FAIL reset_flags: got %b, want 0000", {out_valid, err_data, err_crc, err_op});
    else passed++;
    checks++;
    if (pulse_delta() !== 32'd0) $display("FAIL reset_pulses: got %h, want 0", pulse_delta());
    else passed++;
  endtask

  task automatic test_valid();
    snap();
    send_data(64'd0, 8);
    send_frame(1'b1, 8'h0B, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) $display("FAIL valid_latency: out_valid=%b, want 1", out_valid);
    else passed++;
    exp_a = '0; exp_b = '0; exp_op = 3'b000;
    checks++;
    if ({a, b, op} !== {exp_a, exp_b, exp_op})
      $display("FAIL valid_data: got a=%h b=%h op=%b, want a=%h b=%h op=%b", a, b, op, exp_a, exp_b, exp_op);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL valid_width: out_valid=%b, want 0", out_valid);
    else passed++;
    idle(2);
    checks++;
    if (pulse_delta() !== classify(8, 64'd0, 8'h0B))
      $display("FAIL valid_pulses: got %h, want %h", pulse_delta(), classify(8, 64'd0, 8'h0B));
    else passed++;
  endtask

  task automatic test_error_pkt(input string name, input int ndata, input logic [7:0] cmd);
    logic [63:0] ba;
    ba = {$urandom, $urandom};
    if (ndata == 8 && cmd == 8'h00) ba = '0;
    snap();
    send_data(ba, ndata);
    send_frame(1'b1, cmd, 1'b1);
    idle(3);
    checks++;
    if (pulse_delta() !== classify(ndata, ba, cmd))
      $display("FAIL %s_pulses: got %h, want %h", name, pulse_delta(), classify(ndata, ba, cmd));
    else passed++;
    checks++;
    if ({a, b, op} !== {exp_a, exp_b, exp_op})
      $display("FAIL %s_hold: got a=%h b=%h op=%b, want a=%h b=%h op=%b", name, a, b, op, exp_a, exp_b, exp_op);
    else passed++;
  endtask

  task automatic good_packet(input string name);
    logic [63:0] ba;
    logic [2:0]  o;
    ba = {$urandom, $urandom};
    o  = rand_op();
    snap();
    send_data(ba, 8);
    send_frame(1'b1, {1'b0, o, ref_crc(ba, o)}, 1'b1);
    idle(2);
    exp_b = ba[63:32]; exp_a = ba[31:0]; exp_op = o;
    checks++;
    if (pulse_delta() !== P_V) $display("FAIL %s_pulses: got %h, want %h", name, pulse_delta(), P_V);
    else passed++;
    checks++;
    if ({a, b, op} !== {exp_a, exp_b, exp_op})
      $display("FAIL %s_data: got a=%h b=%h op=%b, want a=%h b=%h op=%b", name, a, b, op, exp_a, exp_b, exp_op);
    else passed++;
  endtask

  task automatic test_framing();
    snap();
    send_frame(1'b0, 8'h5A, 1'b1);
    send_frame(1'b0, 8'hC3, 1'b1);
    send_frame(1'b0, 8'h77, 1'b0);
    idle(4);
    checks++;
    if (pulse_delta() !== P_ED) $display("FAIL framing_pulses: got %h, want %h", pulse_delta(), P_ED);
    else passed++;
    checks++;
    if ({a, b, op} !== {exp_a, exp_b, exp_op})
      $display("FAIL framing_hold: got a=%h b=%h op=%b, want a=%h b=%h op=%b", a, b, op, exp_a, exp_b, exp_op);
    else passed++;
    good_packet("after_framing");
  endtask

  task automatic test_reset_mid();
    logic [63:0] ba;
    ba = {$urandom, $urandom};
    send_data(ba, 4);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    snap();
    @(negedge clk);
    rst_n = 1'b0;
    sin   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = '0; exp_b = '0; exp_op = '0;
    idle(12);
    checks++;
    if ({a, b, op} !== 67'd0) $display("FAIL midreset_outputs: got a=%h b=%h op=%b, want 0", a, b, op);
    else passed++;
    checks++;
    if (pulse_delta() !== 32'd0) $display("FAIL midreset_pulses: got %h, want 0", pulse_delta());
    else passed++;
    good_packet("after_midreset");
  endtask

  task automatic test_back_to_back(input int npkt);
    logic [66:0] exp_q[$];
    logic [63:0] ba;
    logic [2:0]  o;
    got_q.delete();
    snap();
    for (int p = 0; p < npkt; p++) begin
      ba = {$urandom, $urandom};
      o  = rand_op();
      send_data(ba, 8);
      send_frame(1'b1, {1'b0, o, ref_crc(ba, o)}, 1'b1);
      exp_q.push_back({ba[31:0], ba[63:32], o});
    end
    idle(3);
    checks++;
    if (pulse_delta() !== {8'(npkt), 24'd0})
      $display("FAIL b2b_pulses: got %h, want %h", pulse_delta(), {8'(npkt), 24'd0});
    else passed++;
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d, want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_pkt%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_multi !== 0) $display("FAIL exclusive_pulses: got %0d overlapping cycles, want 0", n_multi);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_valid();
    test_error_pkt("bad_crc", 8, 8'h00);
    test_error_pkt("bad_op", 8, 8'h2D);
    test_error_pkt("short", 4, 8'h0B);
    good_packet("after_short");
    test_error_pkt("long", 9, 8'h0B);
    good_packet("after_long");
    test_framing();
    test_reset_mid();
    test_back_to_back(600);
    test_exclusive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule
